// File: rtl/vend_input_arbiter.sv
// Merges button-panel and UART coin/confirm requests into single-cycle events for the
// vending FSM: edge detect, per-source code queues, round-robin issue with a guard gap.

module vend_input_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [1:0] push_code,
  input  logic       pop,
  output logic [1:0] head,
  output logic [2:0] count,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [2:0]    count_r;
  logic          accept_s;
  logic          pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = {AW{1'b0}};
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_s    = pop && (count_r != 3'd0);
  assign accept_s = push && ((count_r != 3'(DEPTH)) || pop_s);
  assign overflow = push && !accept_s;
  assign head     = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign empty    = (count_r == 3'd0);

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= 3'd0;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= push_code;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

module vend_input_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quarter_btn,
  input  logic       dime_btn,
  input  logic       confirm_btn,
  input  logic       quarter_uart,
  input  logic       dime_uart,
  input  logic       confirm_uart,
  input  logic [2:0] fsm_state,
  output logic       quarter_out,
  output logic       dime_out,
  output logic       confirm_out,
  output logic       grant_src,
  output logic       drop_pulse,
  output logic [2:0] btn_count,
  output logic [2:0] uart_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [1:0] CODE_Q = 2'd1;
  localparam logic [1:0] CODE_D = 2'd2;
  localparam logic [1:0] CODE_C = 2'd3;

  // Edge vectors are ordered {confirm, dime, quarter}.
  function automatic logic [1:0] pick_code(input logic [2:0] e);
    if (e[2]) begin
      pick_code = CODE_C;
    end else if (e[0]) begin
      pick_code = CODE_Q;
    end else if (e[1]) begin
      pick_code = CODE_D;
    end else begin
      pick_code = 2'd0;
    end
  endfunction

  function automatic logic multi_edge(input logic [2:0] e);
    multi_edge = (e[0] & e[1]) | (e[0] & e[2]) | (e[1] & e[2]);
  endfunction

  function automatic logic code_legal(input logic [1:0] code, input logic [2:0] st);
    code_legal = ((st == 3'd0) && (code == CODE_C)) ||
                 ((st == 3'd2) && ((code == CODE_Q) || (code == CODE_D)));
  endfunction

  logic [5:0]  raw_s;
  logic [5:0]  prev_r;
  logic [5:0]  edge_r;
  arb_state_t  state_r;
  arb_state_t  state_nxt_s;
  logic        sel_r;
  logic        legal_r;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_nxt_s;
  logic        ready_s;
  logic        cand_s;
  logic [1:0]  cand_code_s;
  logic        issue_s;
  logic        illegal_s;
  logic        pop_btn_s;
  logic        pop_uart_s;
  logic [1:0]  head_btn_s;
  logic [1:0]  head_uart_s;
  logic        empty_btn_s;
  logic        empty_uart_s;
  logic        ovf_btn_s;
  logic        ovf_uart_s;

  assign raw_s   = {confirm_uart, dime_uart, quarter_uart, confirm_btn, dime_btn, quarter_btn};
  assign ready_s = (fsm_state == 3'd0) || (fsm_state == 3'd2);

  // Rising-edge capture; reset preloads the live inputs so held levels never fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= raw_s;
      edge_r <= 6'd0;
    end else begin
      prev_r <= raw_s;
      edge_r <= raw_s & ~prev_r;
    end
  end

  vend_input_fifo #(.DEPTH(FIFO_DEPTH)) u_btn_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (|edge_r[2:0]),
    .push_code (pick_code(edge_r[2:0])),
    .pop       (pop_btn_s),
    .head      (head_btn_s),
    .count     (btn_count),
    .empty     (empty_btn_s),
    .overflow  (ovf_btn_s)
  );

  vend_input_fifo #(.DEPTH(FIFO_DEPTH)) u_uart_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (|edge_r[5:3]),
    .push_code (pick_code(edge_r[5:3])),
    .pop       (pop_uart_s),
    .head      (head_uart_s),
    .count     (uart_count),
    .empty     (empty_uart_s),
    .overflow  (ovf_uart_s)
  );

  // Round-robin candidate: on a tie the source not granted last goes first.
  always_comb begin
    cand_s = 1'b0;
    if (!empty_btn_s && !empty_uart_s) begin
      cand_s = ~grant_src;
    end else if (!empty_btn_s) begin
      cand_s = 1'b0;
    end else begin
      cand_s = 1'b1;
    end
    cand_code_s = cand_s ? head_uart_s : head_btn_s;
  end

  // Arbiter next-state and pop control.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_cnt_r;
    issue_s     = 1'b0;
    illegal_s   = 1'b0;
    pop_btn_s   = 1'b0;
    pop_uart_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ready_s && !(empty_btn_s && empty_uart_s)) begin
          state_nxt_s = ST_ISSUE;
          if (code_legal(cand_code_s, fsm_state)) begin
            issue_s = 1'b1;
          end else begin
            illegal_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        pop_btn_s  = ~sel_r;
        pop_uart_s = sel_r;
        if (legal_r && (GAP_CYCLES > 0)) begin
          state_nxt_s = ST_GAP;
          gap_nxt_s   = GW'(GAP_CYCLES);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r <= GW'(1)) begin
          state_nxt_s = ST_IDLE;
          gap_nxt_s   = {GW{1'b0}};
        end else begin
          gap_nxt_s   = gap_cnt_r - GW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gap_nxt_s   = {GW{1'b0}};
      end
    endcase
  end

  // Arbiter state register; the selection is frozen on entry to ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sel_r     <= 1'b0;
      legal_r   <= 1'b0;
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      sel_r     <= (state_r == ST_IDLE) ? cand_s : sel_r;
      legal_r   <= issue_s;
      gap_cnt_r <= gap_nxt_s;
    end
  end

  // Event pulses are registered so they are high exactly during the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      quarter_out <= 1'b0;
      dime_out    <= 1'b0;
      confirm_out <= 1'b0;
      grant_src   <= 1'b1;
      drop_pulse  <= 1'b0;
    end else begin
      quarter_out <= issue_s && (cand_code_s == CODE_Q);
      dime_out    <= issue_s && (cand_code_s == CODE_D);
      confirm_out <= issue_s && (cand_code_s == CODE_C);
      grant_src   <= issue_s ? cand_s : grant_src;
      drop_pulse  <= illegal_s | ovf_btn_s | ovf_uart_s |
                     multi_edge(edge_r[2:0]) | multi_edge(edge_r[5:3]);
    end
  end

endmodule

// File: tb/tb_vend_input_arbiter.sv
// Directed bench for vend_input_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for arbitration, overflow and reset-during-GAP.

module tb_vend_input_arbiter;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       quarter_btn, dime_btn, confirm_btn;
  logic       quarter_uart, dime_uart, confirm_uart;
  logic [2:0] fsm_state;
  logic       quarter_out, dime_out, confirm_out;
  logic       grant_src, drop_pulse;
  logic [2:0] btn_count, uart_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vend_input_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .quarter_btn  (quarter_btn),
    .dime_btn     (dime_btn),
    .confirm_btn  (confirm_btn),
    .quarter_uart (quarter_uart),
    .dime_uart    (dime_uart),
    .confirm_uart (confirm_uart),
    .fsm_state    (fsm_state),
    .quarter_out  (quarter_out),
    .dime_out     (dime_out),
    .confirm_out  (confirm_out),
    .grant_src    (grant_src),
    .drop_pulse   (drop_pulse),
    .btn_count    (btn_count),
    .uart_count   (uart_count)
  );

  // btn/uart are {confirm, dime, quarter}; exp is {q,d,c,grant,drop,btn_count,uart_count}
  typedef struct {
    logic [2:0]  btn;
    logic [2:0]  uart;
    logic [2:0]  fsm;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkv(input logic [2:0] btn, input logic [2:0] uart, input logic [2:0] fsm,
                               input logic [2:0] qdc, input logic g, input logic dr,
                               input logic [2:0] bc, input logic [2:0] uc);
    vec_t v;
    v.btn = btn;
    v.uart = uart;
    v.fsm = fsm;
    v.exp = {qdc, g, dr, bc, uc};
    return v;
  endfunction

  function automatic logic [10:0] obs();
    return {quarter_out, dime_out, confirm_out, grant_src, drop_pulse, btn_count, uart_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [2:0] btn, input logic [2:0] uart, input logic [2:0] fsm);
    {confirm_btn, dime_btn, quarter_btn}    = btn;
    {confirm_uart, dime_uart, quarter_uart} = uart;
    fsm_state = fsm;
  endtask

  task automatic do_reset(input logic [2:0] fsm);
    reset = 1'b1;
    apply(3'b000, 3'b000, fsm);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int q_at, d_at, nq, nd, multi, drops, outs, uc_max;
    logic q_grant, d_grant;

    // confirm in WaitSel, illegal dime in WaitSel, confirm+quarter collision
    vecs[0]  = mkv(3'b100, 3'b000, 3'd0, 3'b000, 1'b1, 1'b0, 3'd0, 3'd0);
    vecs[1]  = mkv(3'b100, 3'b000, 3'd0, 3'b000, 1'b1, 1'b0, 3'd1, 3'd0);
    vecs[2]  = mkv(3'b100, 3'b000, 3'd0, 3'b001, 1'b0, 1'b0, 3'd1, 3'd0);
    vecs[3]  = mkv(3'b100, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[4]  = mkv(3'b000, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[5]  = mkv(3'b000, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[6]  = mkv(3'b010, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[7]  = mkv(3'b010, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd1, 3'd0);
    vecs[8]  = mkv(3'b010, 3'b000, 3'd0, 3'b000, 1'b0, 1'b1, 3'd1, 3'd0);
    vecs[9]  = mkv(3'b010, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[10] = mkv(3'b000, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[11] = mkv(3'b101, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);
    vecs[12] = mkv(3'b101, 3'b000, 3'd0, 3'b000, 1'b0, 1'b1, 3'd1, 3'd0);
    vecs[13] = mkv(3'b101, 3'b000, 3'd0, 3'b001, 1'b0, 1'b0, 3'd1, 3'd0);
    vecs[14] = mkv(3'b000, 3'b000, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd0);

    do_reset(3'd0);
    check("reset_state", 32'(obs()), 32'({3'b000, 1'b1, 1'b0, 3'd0, 3'd0}));

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].btn, vecs[i].uart, vecs[i].fsm);
      tick();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Simultaneous quarter_btn and dime_uart in WaitPay: button first, UART after the gap
    do_reset(3'd2);
    apply(3'b001, 3'b010, 3'd2);
    q_at = -1; d_at = -1; nq = 0; nd = 0; multi = 0;
    q_grant = 1'bx; d_grant = 1'bx;
    for (int k = 0; k < 20; k++) begin
      tick();
      if ($countones({quarter_out, dime_out, confirm_out}) > 1) multi++;
      if (quarter_out) begin
        nq++;
        if (q_at < 0) begin q_at = k; q_grant = grant_src; end
      end
      if (dime_out) begin
        nd++;
        if (d_at < 0) begin d_at = k; d_grant = grant_src; end
      end
    end
    check("rr_quarter_cycle", 32'(q_at), 32'(2));
    check("rr_quarter_grant", 32'(q_grant), 32'(0));
    check("rr_dime_cycle", 32'(d_at), 32'(2 + GAP + 2));
    check("rr_dime_grant", 32'(d_grant), 32'(1));
    check("rr_pulse_counts", 32'({nq[7:0], nd[7:0]}), 32'({8'd1, 8'd1}));
    check("rr_onehot", 32'(multi), 32'(0));

    // Five UART quarters while the FSM is busy: queue fills, one overflow drop
    do_reset(3'd5);
    drops = 0; outs = 0; uc_max = 0;
    for (int n = 0; n < 6; n++) begin
      for (int h = 0; h < 2; h++) begin
        apply(3'b000, ((n < 5) && (h == 0)) ? 3'b001 : 3'b000, 3'd5);
        tick();
        if (drop_pulse) drops++;
        if (quarter_out || dime_out || confirm_out) outs++;
        if (int'(uart_count) > uc_max) uc_max = int'(uart_count);
      end
    end
    check("ovf_uart_count", 32'(uart_count), 32'(4));
    check("ovf_uart_max", 32'(uc_max), 32'(4));
    check("ovf_drops", 32'(drops), 32'(1));
    check("ovf_no_outputs", 32'(outs), 32'(0));
    apply(3'b000, 3'b000, 3'd2);
    nq = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (quarter_out) nq++;
    end
    check("ovf_released", 32'(nq), 32'(4));
    check("ovf_drained", 32'(uart_count), 32'(0));

    // Reset while in GAP with one event queued in each source
    do_reset(3'd2);
    apply(3'b001, 3'b001, 3'd2);
    tick();
    apply(3'b000, 3'b000, 3'd2);
    tick();
    apply(3'b010, 3'b000, 3'd2);
    tick();
    check("gaprst_issue", 32'({quarter_out, grant_src}), 32'({1'b1, 1'b0}));
    tick();
    check("gaprst_queued", 32'({btn_count, uart_count}), 32'({3'd1, 3'd1}));
    reset = 1'b1;
    apply(3'b111, 3'b111, 3'd2);
    tick();
    check("gaprst_reset", 32'(obs()), 32'({3'b000, 1'b1, 1'b0, 3'd0, 3'd0}));
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("gaprst_quiet%0d", k),
            32'({quarter_out, dime_out, confirm_out, drop_pulse, btn_count, uart_count}), 32'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_input_arbiter.md
VEND_INPUT_ARBITER -- requirements
Module: vend_input_arbiter

Interface
REQ-001 Parameters: FIFO_DEPTH, default 4, entries per source queue; GAP_CYCLES, default 3, idle cycles after each issued event.
REQ-002 Ports: clk  in  1  system clock, all logic on posedge.
REQ-003 Ports: reset  in  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-004 Ports: quarter_btn, dime_btn, confirm_btn  in  1 each  button-panel requests (level, already debounced).
REQ-005 Ports: quarter_uart, dime_uart, confirm_uart  in  1 each  UART-decoded requests (level or pulse).
REQ-006 Ports: fsm_state  in  3  vending FSM state; 0 = WaitSel, 2 = WaitPay, others busy.
REQ-007 Ports: quarter_out, dime_out, confirm_out  out  1 each  single-cycle event pulses to the vending FSM.
REQ-008 Ports: grant_src  out  1  source of the last issued event (0 = button, 1 = UART).
REQ-009 Ports: drop_pulse  out  1  one-cycle pulse when an event is discarded (overflow, collision or illegal-state).
REQ-010 Ports: btn_count, uart_count  out  3 each  current occupancy of each source queue.

Function
REQ-011 Each of the six request inputs SHALL be rising-edge detected with a registered previous value; only a 0->1 transition creates an event.
REQ-012 Event codes SHALL be 2 bits: 1 = quarter, 2 = dime, 3 = confirm.
REQ-013 Each source SHALL own a FIFO of FIFO_DEPTH codes, with one push per cycle at most.
REQ-014 Simultaneous edges within one source SHALL push only the highest-priority code (confirm > quarter > dime); each remaining edge SHALL assert drop_pulse.
REQ-015 A push to a full FIFO SHALL be discarded with drop_pulse asserted; FIFO contents SHALL be unchanged.
REQ-016 A push and pop on the same FIFO in the same cycle SHALL both take effect; occupancy is unchanged, including when the FIFO is full.
REQ-017 Arbiter FSM states SHALL be IDLE, ISSUE and GAP.
REQ-018 IDLE: when fsm_state is 0 or 2 and at least one FIFO is non-empty, the arbiter SHALL select a source round-robin (the source not granted last wins ties) and go to ISSUE.
REQ-019 ISSUE (1 cycle): the arbiter SHALL pop the selected head. If the code is legal for fsm_state (confirm in state 0; quarter or dime in state 2), it SHALL pulse the matching output for exactly one cycle, update grant_src and go to GAP.
REQ-020 ISSUE with an illegal code SHALL pop it, assert drop_pulse, leave all event outputs low and return to IDLE.
REQ-021 GAP SHALL hold all event outputs low for GAP_CYCLES cycles via a down-counter, then return to IDLE.
REQ-022 If fsm_state leaves {0,2} before the ISSUE cycle, the arbiter SHALL remain in IDLE and pop nothing.
REQ-023 At most one of quarter_out, dime_out or confirm_out SHALL be high in any cycle.
REQ-024 Latency from an input edge, with empty queues, arbiter in IDLE and the FSM ready, SHALL be 3 cycles (edge register, push, ISSUE).
REQ-025 Occupancy outputs SHALL be registered and SHALL reflect the FIFO count after the current cycle's push and pop.
REQ-026 drop_pulse SHALL be a single cycle even if several discards coincide.

Reset
REQ-027 While reset is high at a clk edge, the block SHALL enter IDLE, empty both FIFOs, clear the GAP counter and set grant_src = 1 (button wins the first tie).
REQ-028 On reset, all event outputs and drop_pulse SHALL be 0, both counts SHALL be 0, and the edge-detect registers SHALL load the current input values so held inputs do not fire.
REQ-029 Reset during ISSUE or GAP SHALL abort immediately with no output pulse in the cycle after reset.

Verification
REQ-030 fsm_state=0, confirm_btn rises -> confirm_out high for exactly one cycle, 3 cycles after the edge; grant_src=0.
REQ-031 fsm_state=2, quarter_btn and dime_uart rise in the same cycle -> quarter_out (grant_src=0), then GAP_CYCLES idle cycles, then dime_out (grant_src=1).
REQ-032 fsm_state=5, five quarter_uart edges -> uart_count reaches 4, one drop_pulse, no outputs until fsm_state=2.
REQ-033 fsm_state=0, dime_btn edge -> code popped, drop_pulse, dime_out never asserted, btn_count returns to 0.
REQ-034 quarter_btn and confirm_btn rise together in state 0 -> confirm_out issued, one drop_pulse, btn_count peaks at 1.
REQ-035 Reset asserted during GAP with 2 events queued -> counts 0, no event output for the following 5 cycles with inputs held high.
